// File: rtl/spi_luks_if.sv
// ---------------------------------------------------------------------------
// spi_luks_if
//
// Bundles the sensor-side SPI pins and the memory-side request/result
// handshake of the spi_luks light-sensor reader into one interface.
//
// Signals:
//   miso      sensor -> reader   serial data, MSB first
//   valid     writer -> reader   conversion request (level)
//   sclk      reader -> sensor   SPI clock, idles low
//   ss        reader -> sensor   slave select, active-low
//   ready     reader -> writer   one-cycle strobe when toMemory updates
//   toMemory  reader -> writer   latest 8-bit light value
//
// Modports:
//   master  view used by the spi_luks reader itself
//   slave   view used by whatever surrounds it (sensor + memory writer)
// ---------------------------------------------------------------------------
interface spi_luks_if;
    logic       miso;
    logic       valid;
    logic       sclk;
    logic       ss;
    logic       ready;
    logic [7:0] toMemory;

    modport master (
        input  miso,
        input  valid,
        output sclk,
        output ss,
        output ready,
        output toMemory
    );

    modport slave (
        output miso,
        output valid,
        input  sclk,
        input  ss,
        input  ready,
        input  toMemory
    );
endinterface

// File: rtl/spi_luks.sv
// ---------------------------------------------------------------------------
// spi_luks
//
// SPI master that reads one 16-bit frame from a PmodALS-style ambient-light
// sensor and hands the 8-bit light value to a memory/register writer.
//
// Ports:
//   clk   system clock, everything updates on its rising edge
//   rstn  asynchronous reset, ACTIVE-HIGH despite the name
//   bus   spi_luks_if.master: miso/valid in, sclk/ss/ready/toMemory out
//
// Parameters:
//   CLK_DIV     sclk half-period in clk cycles (>= 1)
//   FRAME_BITS  sclk cycles per frame
//   DATA_LSB    frame bit index of the result LSB
//
// Optional feature (compile-time macro SPI_LUKS_AUTO_RESTART_EN):
//   defined   -> after a result, go straight back to IDLE so a held valid
//                gives continuous back-to-back frames
//   undefined -> after a result, wait for valid to drop before re-arming
// ---------------------------------------------------------------------------
module spi_luks #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 16,
    parameter int DATA_LSB   = 4
) (
    input  logic clk,
    input  logic rstn,
    spi_luks_if.master bus
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_FINAL  = BIT_W'(FRAME_BITS);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_SHIFT    = 3'd2;
    localparam logic [2:0] S_HOLD     = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_WAIT_LOW = 3'd5;

    logic [2:0]            r_state;
    logic [DIV_W-1:0]      r_divCnt;
    logic [BIT_W-1:0]      r_bitCnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_sclk;
    logic                  r_ss;
    logic                  r_ready;
    logic [7:0]            r_toMemory;

    logic                  w_divDone;
    logic [7:0]            w_result;

    // Every phase (setup, sclk high, sclk low, hold) lasts CLK_DIV cycles;
    // the divider counter runs 0..CLK_DIV-1 and this flags its last cycle.
    assign w_divDone = (r_divCnt == DIV_LAST);

    // Once all bits are in, the shift register holds the frame MSB..LSB.
    assign w_result  = r_shift[DATA_LSB+7:DATA_LSB];

    // Single sequential block: state, counters and all outputs are
    // registered together so sclk/ss/ready never glitch.
    // In SHIFT, sclk toggles at the end of each half-period; the edge that
    // drops sclk is also the edge that samples miso, since the sensor
    // changed it a full half-period earlier on the rising edge. After the
    // final falling edge the low half-period still runs out before HOLD.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state    <= S_IDLE;
            r_divCnt   <= '0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_sclk     <= 1'b0;
            r_ss       <= 1'b1;
            r_ready    <= 1'b0;
            r_toMemory <= 8'h00;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sclk   <= 1'b0;
                    r_ss     <= 1'b1;
                    r_divCnt <= '0;
                    r_bitCnt <= '0;
                    if (bus.valid) begin
                        r_ss    <= 1'b0;
                        r_shift <= '0;
                        r_state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (w_divDone) begin
                        r_divCnt <= '0;
                        r_sclk   <= 1'b1;
                        r_state  <= S_SHIFT;
                    end else begin
                        r_divCnt <= r_divCnt + DIV_W'(1);
                    end
                end

                S_SHIFT: begin
                    if (!w_divDone) begin
                        r_divCnt <= r_divCnt + DIV_W'(1);
                    end else begin
                        r_divCnt <= '0;
                        if (r_sclk) begin
                            r_sclk   <= 1'b0;
                            r_shift  <= {r_shift[FRAME_BITS-2:0], bus.miso};
                            r_bitCnt <= r_bitCnt + BIT_W'(1);
                        end else if (r_bitCnt == BIT_FINAL) begin
                            r_ss    <= 1'b1;
                            r_state <= S_HOLD;
                        end else begin
                            r_sclk <= 1'b1;
                        end
                    end
                end

                S_HOLD: begin
                    if (w_divDone) begin
                        r_divCnt   <= '0;
                        r_ready    <= 1'b1;
                        r_toMemory <= w_result;
                        r_state    <= S_DONE;
                    end else begin
                        r_divCnt <= r_divCnt + DIV_W'(1);
                    end
                end

                S_DONE: begin
`ifdef SPI_LUKS_AUTO_RESTART_EN
                    r_state <= S_IDLE;
`else
                    r_state <= S_WAIT_LOW;
`endif
                end

                S_WAIT_LOW: begin
                    if (!bus.valid) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_sclk  <= 1'b0;
                    r_ss    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.sclk     = r_sclk;
    assign bus.ss       = r_ss;
    assign bus.ready    = r_ready;
    assign bus.toMemory = r_toMemory;

endmodule

// File: tb/tb_spi_luks.sv
// ---------------------------------------------------------------------------
// tb_spi_luks
//
// Self-checking bench for spi_luks with default parameters. A behavioural
// sensor shifts a 16-bit frame out MSB-first on each sclk rising edge while
// ss is low; the expected light value is simply (frame >> 4) & 8'hFF, and the
// expected request-to-ready latency is 1 + D + 32*D + D edges for D = 4.
// ---------------------------------------------------------------------------
module tb_spi_luks;

    localparam int CLK_DIV    = 4;
    localparam int DATA_LSB   = 4;
    localparam int FRAME_BITS = 16;
    localparam int EXP_LAT    = 1 + CLK_DIV + FRAME_BITS * 2 * CLK_DIV + CLK_DIV;

    logic clk;
    logic rstn;

    spi_luks_if bus ();

    spi_luks #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_BITS (FRAME_BITS),
        .DATA_LSB   (DATA_LSB)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    int checks      = 0;
    int passes      = 0;
    int fails       = 0;
    int sclkPulses  = 0;
    int sclkAll     = 0;
    int sclkSsHigh  = 0;
    int readyCycles = 0;
    int framePulses = 0;
    int sensorIdx   = 0;
    logic [15:0] sensorFrame = 16'h0000;

    // Free-running system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sensor model: restart on ss high, present the next frame bit on each
    // sclk rising edge while selected.
    always @(posedge bus.sclk or posedge bus.ss) begin
        if (bus.ss === 1'b1) begin
            sensorIdx = 0;
        end else begin
            if (sensorIdx < FRAME_BITS) begin
                bus.miso = sensorFrame[FRAME_BITS-1-sensorIdx];
            end else begin
                bus.miso = 1'b0;
            end
            sensorIdx++;
        end
    end

    // Pin monitors: sclk pulses inside a frame, any sclk rise at all, and
    // sclk rising while the sensor is deselected.
    always @(posedge bus.sclk) begin
        sclkAll++;
        if (bus.ss === 1'b0) sclkPulses++;
        else                 sclkSsHigh++;
    end

    // Counts clock cycles in which ready was high.
    always @(posedge clk) begin
        if (bus.ready === 1'b1) readyCycles++;
    end

    // Single comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Request one frame and wait (bounded) for ready. Latency counts rising
    // edges from the one that samples valid up to the one that raises ready.
    task automatic applyStimulus(input logic [15:0] frame, input int dropAt,
                                 output int latency, output bit gotReady);
        int startPulses;
        sensorFrame = frame;
        startPulses = sclkPulses;
        @(negedge clk);
        bus.valid = 1'b1;
        latency   = 0;
        gotReady  = 1'b0;
        for (int c = 0; c < 1000 && !gotReady; c++) begin
            @(posedge clk);
            #1;
            latency++;
            if (dropAt > 0 && (sclkPulses - startPulses) >= dropAt) bus.valid = 1'b0;
            if (bus.ready === 1'b1) gotReady = 1'b1;
        end
        framePulses = sclkPulses - startPulses;
    endtask

    // Standard checks after a frame: arrival, data, latency, pulse count and
    // a one-cycle-wide ready.
    task automatic verifyFrame(input string tag, input logic [15:0] frame,
                               input int latency, input bit gotReady);
        logic [7:0] expData;
        expData = 8'((frame >> DATA_LSB) & 16'h00FF);
        checkOutput({tag, "_ready"}, 32'(gotReady), 32'd1);
        checkOutput({tag, "_data"}, 32'(bus.toMemory), 32'(expData));
        checkOutput({tag, "_latency"}, 32'(latency), 32'(EXP_LAT));
        checkOutput({tag, "_pulses"}, 32'(framePulses), 32'(FRAME_BITS));
        @(posedge clk);
        #1;
        checkOutput({tag, "_readyWidth"}, 32'(bus.ready), 32'd0);
    endtask

    initial begin : mainSeq
        int          lat;
        bit          got;
        int          startReady;
        int          ssLow;
        int          t1;
        int          t2;
        logic [15:0] frame;

        bus.valid = 1'b0;
        bus.miso  = 1'b0;
        rstn      = 1'b1;

        // Reset state.
        repeat (5) @(posedge clk);
        #1;
        checkOutput("reset_sclk", 32'(bus.sclk), 32'd0);
        checkOutput("reset_ss", 32'(bus.ss), 32'd1);
        checkOutput("reset_ready", 32'(bus.ready), 32'd0);
        checkOutput("reset_toMemory", 32'(bus.toMemory), 32'h00);
        checkOutput("reset_noSclk", 32'(sclkAll), 32'd0);
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(posedge clk);

        // Basic read.
        $display("[TB] basic read");
        applyStimulus(16'h0050, 0, lat, got);
        verifyFrame("basic", 16'h0050, lat, got);

`ifndef SPI_LUKS_AUTO_RESTART_EN
        // Handshake: valid held high must not start another frame.
        $display("[TB] handshake");
        ssLow = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (bus.ss !== 1'b1) ssLow++;
        end
        checkOutput("hold_noSecondFrame", 32'(ssLow), 32'd0);
        bus.valid = 1'b0;
        repeat (3) @(posedge clk);
        applyStimulus(16'h0FF0, 0, lat, got);
        verifyFrame("rearm", 16'h0FF0, lat, got);
`endif
        bus.valid = 1'b0;
        repeat (3) @(posedge clk);

        // valid dropped after the 5th sclk pulse: frame still completes.
        $display("[TB] valid dropped mid-frame");
        startReady = readyCycles;
        frame = 16'($urandom);
        applyStimulus(frame, 5, lat, got);
        verifyFrame("dropValid", frame, lat, got);
        checkOutput("dropValid_readyCount", 32'(readyCycles - startReady), 32'd1);
        bus.valid = 1'b0;
        repeat (3) @(posedge clk);

        // Reset after the 8th sclk pulse aborts the frame immediately.
        $display("[TB] reset mid-frame");
        sensorFrame = 16'hA5A5;
        startReady  = readyCycles;
        t1 = sclkPulses;
        @(negedge clk);
        bus.valid = 1'b1;
        for (int c = 0; c < 1000 && (sclkPulses - t1) < 8; c++) @(posedge clk);
        checkOutput("midReset_reached8", 32'((sclkPulses - t1) >= 8), 32'd1);
        #3;
        rstn = 1'b1;
        #1;
        checkOutput("midReset_ss", 32'(bus.ss), 32'd1);
        checkOutput("midReset_sclk", 32'(bus.sclk), 32'd0);
        checkOutput("midReset_toMemory", 32'(bus.toMemory), 32'h00);
        bus.valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("midReset_noReady", 32'(readyCycles - startReady), 32'd0);
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(posedge clk);

        // Randomized reads after the aborted frame.
        $display("[TB] random reads");
        for (int i = 0; i < 4; i++) begin
            frame = 16'($urandom);
            applyStimulus(frame, 0, lat, got);
            verifyFrame($sformatf("random%0d", i), frame, lat, got);
            bus.valid = 1'b0;
            repeat (3) @(posedge clk);
        end

`ifdef SPI_LUKS_AUTO_RESTART_EN
        // Continuous sampling: consecutive ready pulses are one frame plus
        // one IDLE cycle apart.
        $display("[TB] auto restart");
        frame = 16'($urandom);
        startReady = readyCycles;
        applyStimulus(frame, 0, lat, got);
        verifyFrame("auto1", frame, lat, got);
        t1 = 0;
        got = 1'b0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(posedge clk);
            #1;
            t1++;
            if (bus.ready === 1'b1) got = 1'b1;
        end
        checkOutput("auto2_ready", 32'(got), 32'd1);
        checkOutput("auto2_data", 32'(bus.toMemory), 32'(8'((frame >> DATA_LSB) & 16'h00FF)));
        checkOutput("auto_interval", 32'(t1 + 1), 32'(EXP_LAT + 1));
        t2 = readyCycles - startReady;
        checkOutput("auto_readyCount", 32'(t2), 32'd1);
        bus.valid = 1'b0;
        repeat (200) @(posedge clk);
`endif

        checkOutput("sclkWhileDeselected", 32'(sclkSsHigh), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spi_luks.md
Name: spi_luks

Overview:
- SPI master that reads one 16-bit frame from an ambient-light sensor ADC (PmodALS-style: leading zeros, 8 data bits, trailing zeros).
- Delivers the 8-bit light value on toMemory with a one-cycle ready strobe.
- Sits between the sensor pins (sclk/ss/miso) and a memory/register writer that requests samples with valid.

Parameters:
- CLK_DIV, default 4: sclk half-period in clk cycles; legal values are 1 or greater. Full sclk period is 2*CLK_DIV clk cycles.
- FRAME_BITS, default 16: number of sclk cycles per frame.
- DATA_LSB, default 4: frame bit index of the LSB of the 8-bit result, so the result is frame[DATA_LSB+7:DATA_LSB].

Ports:
- clk, input, 1: system clock. All logic updates on its rising edge.
- rstn, input, 1: asynchronous reset, active-high despite the name. Asserting it (1) resets the block immediately.
- miso, input, 1: serial data from the sensor, MSB first.
- valid, input, 1: conversion request, level-sensitive.
- sclk, output, 1: SPI clock. CPOL=0, so it idles low.
- ss, output, 1: slave select, active-low. Idles high.
- ready, output, 1: one-cycle pulse when toMemory has been updated.
- toMemory, output, 8: latest light value. Held until the next update.

Behaviour:
- Reset (rstn=1, asynchronous): sclk=0, ss=1, ready=0, toMemory=8'h00, shift register cleared, state=IDLE, divider counter cleared. Reset mid-frame aborts the frame immediately with no ready pulse.
- All outputs are registered.
- States: IDLE, SETUP, SHIFT, HOLD, DONE, WAIT_LOW.
- IDLE: ss=1, sclk=0. If valid=1, go to SETUP on the next clk.
- SETUP: ss=0, sclk=0 for CLK_DIV cycles, then go to SHIFT.
- SHIFT: 16 bit periods. Each bit period is sclk=1 for CLK_DIV cycles, then sclk=0 for CLK_DIV cycles.
  - The sensor changes miso on the sclk rising edge.
  - On the clk edge that drives sclk 1->0, the block samples miso into the shift register LSB (shift left).
  - First sample is frame bit 15.
  - After the 16th falling edge, go to HOLD. sclk stays 0.
- HOLD: ss=1, sclk=0 for CLK_DIV cycles, then go to DONE.
- DONE (1 cycle): toMemory <= frame[DATA_LSB+7:DATA_LSB], which is frame[11:4] by default; ready=1 in this same cycle.
  - Next state is WAIT_LOW, or IDLE if the optional feature is enabled.
- WAIT_LOW: return to IDLE only when valid=0. Exactly one conversion is performed per valid assertion.
- ready is 0 in every state except DONE.
- valid dropping mid-frame does not abort the frame; the frame completes and ready still pulses.
- Latency from the valid-sampled edge to ready: 1 + CLK_DIV + 16*2*CLK_DIV + CLK_DIV cycles, which is 137 cycles for CLK_DIV=4.
- The frame holds exactly 16 sclk rising edges while ss=0. sclk never toggles while ss=1.

Optional Feature:
- Macro: SPI_LUKS_AUTO_RESTART_EN.
- Defined: DONE goes straight to IDLE. If valid is still 1, a new frame starts; ss returns low after exactly 1 IDLE cycle, giving continuous sampling while valid is held.
- Undefined: DONE goes to WAIT_LOW, so valid must be seen low before the next frame.

Test Plan:
- Reset: hold rstn=1 for 5 clk -> sclk=0, ss=1, ready=0, toMemory=8'h00. No sclk edges while in reset.
- Basic read: sensor model drives frame 16'h0050 MSB-first, updating on the sclk rising edge; assert valid -> exactly 16 sclk pulses with ss low; ready pulses for 1 cycle; toMemory=8'h05. ready occurs 137 cycles after valid is sampled (CLK_DIV=4).
- Handshake: keep valid=1 after ready (macro off) -> no second frame; ss stays 1. Drop valid, then reassert it with frame 16'h0FF0 -> toMemory=8'hFF.
- valid deasserted mid-frame (after the 5th sclk pulse) -> frame still completes; ready pulses; toMemory updates.
- Reset mid-frame (after the 8th sclk pulse) -> ss goes high and sclk goes low immediately; no ready; toMemory keeps 8'h00. A subsequent valid gives a correct full read.
- With SPI_LUKS_AUTO_RESTART_EN and valid held high -> back-to-back frames with a 1-cycle IDLE gap; ready pulses once per frame.
